// File: rtl/z88_xmem_bridge_pkg.sv
// ---------------------------------------------------------------------------
// z88_pkg
// Shared definitions for the Z88 external-memory bridge: FSM state encoding,
// device data-width legality check and byte-lane count helper.
// No ports (package).
// ---------------------------------------------------------------------------
package z88_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_RD    = 3'd1;
    localparam state_t ST_WR_SU = 3'd2;
    localparam state_t ST_WR_P  = 3'd3;
    localparam state_t ST_WR_H  = 3'd4;
    localparam state_t ST_DONE  = 3'd5;

    function automatic bit mem_dw_legal(input int dw);
        return (dw == 8) || (dw == 16);
    endfunction

    function automatic int lane_count(input int dw);
        return dw / 8;
    endfunction

endpackage

// File: rtl/z88_xmem_bridge_if.sv
// ---------------------------------------------------------------------------
// z88_xmem_bridge_if
// Host-side request/acknowledge bus between the Z88 core and one memory
// bridge instance.
//   req, we, addr, wdata : host -> bridge (sampled together on accept)
//   rdata, ack, busy     : bridge -> host
// Modports: master (Z88 core side), slave (bridge side).
// ---------------------------------------------------------------------------
interface z88_xmem_bridge_if #(
    parameter int HOST_AW = 19
) ();
    logic               req;
    logic               we;
    logic [HOST_AW-1:0] addr;
    logic [7:0]         wdata;
    logic [7:0]         rdata;
    logic               ack;
    logic               busy;

    modport master (output req, we, addr, wdata, input rdata, ack, busy);
    modport slave  (input req, we, addr, wdata, output rdata, ack, busy);
endinterface

// File: rtl/z88_xmem_bridge.sv
// ---------------------------------------------------------------------------
// z88_xmem_bridge
// Sequenced bridge from the Z88 8-bit host bus to one external async SRAM or
// flash device (8 or 16 bits wide). Generates timed CE/OE/WE strobes with
// write setup/hold, registers address/byte-enables for the whole access and
// captures read data into rdata.
// Ports:
//   clk, reset_n      clock, async active-low reset
//   host (slave)      req/we/addr/wdata in, rdata/ack/busy out
//   mem_addr          device word address
//   mem_dq_o/oe/i     data pad out, pad output enable, data pad in
//   mem_ce_n/oe_n/we_n strobes
//   mem_be_n          byte enables, bit0 = low lane
// All pad outputs are registered from the state, so they trail the state
// register by one cycle; ack therefore appears the cycle after DONE.
//
// state    | meaning
// ---------+----------------------------------------------
// IDLE     | waiting for req (ignored while busy is high)
// RD       | CE/OE low, RD_WAIT+1 cycles
// WR_SU    | CE low, data driven, WE high (setup)
// WR_P     | WE low, WR_WAIT+1 cycles
// WR_H     | WE high, data still driven (hold)
// DONE     | strobes released, ack issued next cycle
// ---------------------------------------------------------------------------
module z88_xmem_bridge
    import z88_pkg::*;
#(
    parameter int HOST_AW   = 19,
    parameter int MEM_DW    = 16,
    parameter int RD_WAIT   = 1,
    parameter int WR_WAIT   = 1,
    parameter bit WR_ENABLE = 1'b1
) (
    input  logic                          clk,
    input  logic                          reset_n,
    z88_xmem_bridge_if.slave              host,
    output logic [HOST_AW-MEM_DW/16-1:0]  mem_addr,
    output logic [MEM_DW-1:0]             mem_dq_o,
    output logic                          mem_dq_oe,
    input  logic [MEM_DW-1:0]             mem_dq_i,
    output logic                          mem_ce_n,
    output logic                          mem_oe_n,
    output logic                          mem_we_n,
    output logic [MEM_DW/8-1:0]           mem_be_n
);

    localparam int NLANE = lane_count(MEM_DW);
    localparam int MAW   = HOST_AW - MEM_DW / 16;

    generate
        if (!mem_dw_legal(MEM_DW)) begin : g_bad_dw
            $error("z88_xmem_bridge: MEM_DW must be 8 or 16");
        end
        if (RD_WAIT < 0 || RD_WAIT > 15 || WR_WAIT < 0 || WR_WAIT > 15) begin : g_bad_wait
            $error("z88_xmem_bridge: RD_WAIT/WR_WAIT must be 0..15");
        end
    endgenerate

    state_t           state;
    logic [3:0]       wait_cnt;
    logic             lat_we;
    logic             lat_hi;
    logic [7:0]       rdata_q;
    logic             ack_q;
    logic             busy_q;
    logic [MAW-1:0]   addr_acc;
    logic [NLANE-1:0] be_acc;
    logic [7:0]       lane_byte;

    assign host.rdata = rdata_q;
    assign host.ack   = ack_q;
    assign host.busy  = busy_q;

    // Host byte address -> device word address / lane select.
    generate
        if (MEM_DW == 16) begin : g_w16
            assign addr_acc  = host.addr[HOST_AW-1:1];
            assign be_acc    = host.addr[0] ? 2'b01 : 2'b10;
            assign lane_byte = lat_hi ? mem_dq_i[15:8] : mem_dq_i[7:0];
        end else begin : g_w8
            assign addr_acc  = host.addr;
            assign be_acc    = '0;
            assign lane_byte = mem_dq_i[7:0];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            wait_cnt  <= '0;
            lat_we    <= 1'b0;
            lat_hi    <= 1'b0;
            mem_addr  <= '0;
            mem_be_n  <= '1;
            mem_dq_o  <= '0;
            mem_dq_oe <= 1'b0;
            mem_ce_n  <= 1'b1;
            mem_oe_n  <= 1'b1;
            mem_we_n  <= 1'b1;
            rdata_q   <= '0;
            ack_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            // OE and dq_oe decode from disjoint states, so they never overlap.
            mem_ce_n  <= !(state inside {ST_RD, ST_WR_SU, ST_WR_P, ST_WR_H});
            mem_oe_n  <= (state != ST_RD);
            mem_we_n  <= (state != ST_WR_P);
            mem_dq_oe <= (state inside {ST_WR_SU, ST_WR_P, ST_WR_H});
            ack_q     <= (state == ST_DONE);
            if (ack_q) busy_q <= 1'b0;

            case (state)
                ST_IDLE: begin
                    // busy_q still high during the ack cycle keeps one idle gap.
                    if (host.req && !busy_q) begin
                        busy_q   <= 1'b1;
                        lat_we   <= host.we;
                        lat_hi   <= host.addr[0];
                        mem_addr <= addr_acc;
                        mem_be_n <= be_acc;
                        if (!host.we) begin
                            state    <= ST_RD;
                            wait_cnt <= 4'(RD_WAIT);
                        end else if (WR_ENABLE) begin
                            state    <= ST_WR_SU;
                            mem_dq_o <= {NLANE{host.wdata}};
                        end else begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_RD: begin
                    if (wait_cnt == 4'd0) state <= ST_DONE;
                    else                  wait_cnt <= wait_cnt - 4'd1;
                end
                ST_WR_SU: begin
                    state    <= ST_WR_P;
                    wait_cnt <= 4'(WR_WAIT);
                end
                ST_WR_P: begin
                    if (wait_cnt == 4'd0) state <= ST_WR_H;
                    else                  wait_cnt <= wait_cnt - 4'd1;
                end
                ST_WR_H: state <= ST_DONE;
                ST_DONE: begin
                    state <= ST_IDLE;
                    // Pads still show the last RD cycle here, so this is the capture edge.
                    if (!lat_we) rdata_q <= lane_byte;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_z88_xmem_bridge.sv
// ---------------------------------------------------------------------------
// tb_z88_xmem_bridge
// Two bridge instances: a 16-bit SRAM (RD_WAIT=2, WR_WAIT=3) and an 8-bit
// read-only flash (RD_WAIT=0, WR_WAIT=1, WR_ENABLE=0). Each access is
// compared against latency/strobe-count/lane rules computed directly from
// the device parameters.
// ---------------------------------------------------------------------------
module tb_z88_xmem_bridge;

    localparam int W16_RD = 2;
    localparam int W16_WR = 3;
    localparam int W8_RD  = 0;
    localparam int W8_WR  = 1;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    logic        sel;
    logic        req_drv;
    logic        we_drv;
    logic [18:0] addr_drv;
    logic [7:0]  wdata_drv;
    logic [15:0] dq_i16;
    logic [7:0]  dq_i8;
    logic [7:0]  last_rd [2];

    z88_xmem_bridge_if #(.HOST_AW(19)) h16 ();
    z88_xmem_bridge_if #(.HOST_AW(19)) h8 ();

    assign h16.req   = req_drv & ~sel;
    assign h16.we    = we_drv;
    assign h16.addr  = addr_drv;
    assign h16.wdata = wdata_drv;
    assign h8.req    = req_drv & sel;
    assign h8.we     = we_drv;
    assign h8.addr   = addr_drv;
    assign h8.wdata  = wdata_drv;

    logic [17:0] m16_addr;
    logic [15:0] m16_dq_o;
    logic        m16_dq_oe, m16_ce_n, m16_oe_n, m16_we_n;
    logic [1:0]  m16_be_n;
    logic [18:0] m8_addr;
    logic [7:0]  m8_dq_o;
    logic        m8_dq_oe, m8_ce_n, m8_oe_n, m8_we_n;
    logic [0:0]  m8_be_n;

    z88_xmem_bridge #(.HOST_AW(19), .MEM_DW(16), .RD_WAIT(W16_RD), .WR_WAIT(W16_WR), .WR_ENABLE(1'b1)) u16 (
        .clk(clk), .reset_n(reset_n), .host(h16),
        .mem_addr(m16_addr), .mem_dq_o(m16_dq_o), .mem_dq_oe(m16_dq_oe), .mem_dq_i(dq_i16),
        .mem_ce_n(m16_ce_n), .mem_oe_n(m16_oe_n), .mem_we_n(m16_we_n), .mem_be_n(m16_be_n)
    );

    z88_xmem_bridge #(.HOST_AW(19), .MEM_DW(8), .RD_WAIT(W8_RD), .WR_WAIT(W8_WR), .WR_ENABLE(1'b0)) u8 (
        .clk(clk), .reset_n(reset_n), .host(h8),
        .mem_addr(m8_addr), .mem_dq_o(m8_dq_o), .mem_dq_oe(m8_dq_oe), .mem_dq_i(dq_i8),
        .mem_ce_n(m8_ce_n), .mem_oe_n(m8_oe_n), .mem_we_n(m8_we_n), .mem_be_n(m8_be_n)
    );

    logic        o_ack, o_busy, o_ce_n, o_oe_n, o_we_n, o_dq_oe;
    logic [7:0]  o_rdata;
    logic [18:0] o_addr;
    logic [1:0]  o_be;
    logic [15:0] o_dq;

    always_comb begin
        o_ack   = sel ? h8.ack   : h16.ack;
        o_busy  = sel ? h8.busy  : h16.busy;
        o_rdata = sel ? h8.rdata : h16.rdata;
        o_ce_n  = sel ? m8_ce_n  : m16_ce_n;
        o_oe_n  = sel ? m8_oe_n  : m16_oe_n;
        o_we_n  = sel ? m8_we_n  : m16_we_n;
        o_dq_oe = sel ? m8_dq_oe : m16_dq_oe;
        o_addr  = sel ? m8_addr  : {1'b0, m16_addr};
        o_be    = sel ? {1'b0, m8_be_n} : m16_be_n;
        o_dq    = sel ? {8'h00, m8_dq_o} : m16_dq_o;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One complete access; starts and ends 1 time unit after a rising edge.
    task automatic access(input bit s, input bit w, input logic [18:0] a,
                          input logic [7:0] d, input logic [15:0] dqi);
        int rdw, wrw, exp_lat, exp_ce, exp_oe, exp_we, exp_dqoe;
        int lat, ce_c, oe_c, we_c, dqoe_c;
        bit wen, ack_seen, cont, we_out, busy_gap, moved, have0;
        logic [18:0] addr0, exp_addr;
        logic [1:0]  be0, exp_be;
        logic [15:0] dq_at_ack;

        rdw = s ? W8_RD : W16_RD;
        wrw = s ? W8_WR : W16_WR;
        wen = !s;
        exp_lat  = !w ? rdw + 3 : (wen ? wrw + 5 : 2);
        exp_ce   = !w ? rdw + 1 : (wen ? wrw + 3 : 0);
        exp_oe   = !w ? rdw + 1 : 0;
        exp_we   = (w && wen) ? wrw + 1 : 0;
        exp_dqoe = (w && wen) ? wrw + 3 : 0;
        exp_addr = s ? a : {1'b0, a[18:1]};
        exp_be   = s ? 2'b00 : (a[0] ? 2'b01 : 2'b10);
        if (!w) last_rd[s] = s ? dqi[7:0] : (a[0] ? dqi[15:8] : dqi[7:0]);

        lat = 0; ce_c = 0; oe_c = 0; we_c = 0; dqoe_c = 0;
        ack_seen = 0; cont = 0; we_out = 0; busy_gap = 0; moved = 0; have0 = 0;
        addr0 = '0; be0 = '0; dq_at_ack = '0;

        sel = s;
        if (s) dq_i8 = dqi[7:0];
        else   dq_i16 = dqi;
        we_drv = w; addr_drv = a; wdata_drv = d;
        #0;
        chk("pre_busy", 32'(o_busy), 32'(0));
        req_drv = 1'b1;
        for (int n = 1; n <= 40 && !ack_seen; n++) begin
            @(posedge clk); #1;
            req_drv = 1'b0;
            if (!o_ce_n) begin
                ce_c++;
                if (!have0) begin addr0 = o_addr; be0 = o_be; have0 = 1; end
                else if (o_addr !== addr0 || o_be !== be0) moved = 1;
            end
            if (!o_oe_n) oe_c++;
            if (o_dq_oe) dqoe_c++;
            if (!o_we_n) begin we_c++; if (o_ce_n) we_out = 1; end
            if (o_dq_oe && !o_oe_n) cont = 1;
            if (!o_busy) busy_gap = 1;
            if (o_ack) begin ack_seen = 1; lat = n; dq_at_ack = o_dq; end
        end
        chk("latency",    32'(lat),      32'(exp_lat));
        chk("rdata",      32'(o_rdata),  32'(last_rd[s]));
        chk("ce_cycles",  32'(ce_c),     32'(exp_ce));
        chk("oe_cycles",  32'(oe_c),     32'(exp_oe));
        chk("we_cycles",  32'(we_c),     32'(exp_we));
        chk("dqoe_cycles",32'(dqoe_c),   32'(exp_dqoe));
        chk("contention", 32'(cont),     32'(0));
        chk("we_out_ce",  32'(we_out),   32'(0));
        chk("busy_gap",   32'(busy_gap), 32'(0));
        chk("addr_moved", 32'(moved),    32'(0));
        if (exp_ce > 0) begin
            chk("mem_addr", 32'(addr0), 32'(exp_addr));
            chk("be_n",     32'(be0),   32'(exp_be));
        end
        if (w && wen) chk("dq_o", 32'(dq_at_ack), 32'({d, d}));
        @(posedge clk); #1;
        chk("post_ack",  32'(o_ack),  32'(0));
        chk("post_busy", 32'(o_busy), 32'(0));
    endtask

    task automatic reset_mid_write();
        int waited;
        waited = 0;
        sel = 1'b0; we_drv = 1'b1; addr_drv = 19'h00005; wdata_drv = 8'hA5; req_drv = 1'b1;
        @(posedge clk); #1;
        req_drv = 1'b0;
        while (m16_we_n && waited < 20) begin @(posedge clk); #1; waited++; end
        chk("rst_in_wr_p", 32'(m16_we_n), 32'(0));
        #2 reset_n = 1'b0;
        #1;
        chk("rst_we_n",  32'(m16_we_n),  32'(1));
        chk("rst_ce_n",  32'(m16_ce_n),  32'(1));
        chk("rst_dq_oe", 32'(m16_dq_oe), 32'(0));
        chk("rst_busy",  32'(h16.busy),  32'(0));
        chk("rst_be_n",  32'(m16_be_n),  32'(2'b11));
        last_rd[0] = 8'h00;
        last_rd[1] = 8'h00;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_rel_busy", 32'(h16.busy), 32'(0));
        chk("rst_rel_ce_n", 32'(m16_ce_n), 32'(1));
        chk("rst_rel_rdata", 32'(h16.rdata), 32'(0));
    endtask

    task automatic hold_req();
        int acks, bad;
        bit prev_ack, adjacent;
        acks = 0; bad = 0; prev_ack = 0; adjacent = 0;
        sel = 1'b1; we_drv = 1'b0; addr_drv = 19'($urandom); dq_i8 = 8'($urandom);
        req_drv = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            @(posedge clk); #1;
            if (h8.ack !== ((n % 4) == 3)) bad++;
            if (h8.busy !== ((n % 4) != 0)) bad++;
            if (h8.ack) acks++;
            if (h8.ack && prev_ack) adjacent = 1;
            prev_ack = h8.ack;
        end
        req_drv = 1'b0;
        last_rd[1] = dq_i8;
        chk("hold_acks",     32'(acks),     32'(3));
        chk("hold_pattern",  32'(bad),      32'(0));
        chk("hold_adjacent", 32'(adjacent), 32'(0));
        chk("hold_rdata",    32'(h8.rdata), 32'(last_rd[1]));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; sel = 1'b0; req_drv = 1'b0; we_drv = 1'b0;
        addr_drv = '0; wdata_drv = '0; dq_i16 = '0; dq_i8 = '0;
        last_rd[0] = 8'h00; last_rd[1] = 8'h00;
        #12;
        chk("init_ce_n16",  32'(m16_ce_n),  32'(1));
        chk("init_oe_n16",  32'(m16_oe_n),  32'(1));
        chk("init_we_n16",  32'(m16_we_n),  32'(1));
        chk("init_be_n16",  32'(m16_be_n),  32'(2'b11));
        chk("init_dq_oe16", 32'(m16_dq_oe), 32'(0));
        chk("init_dq_o16",  32'(m16_dq_o),  32'(0));
        chk("init_addr16",  32'(m16_addr),  32'(0));
        chk("init_rdata16", 32'(h16.rdata), 32'(0));
        chk("init_busy16",  32'(h16.busy),  32'(0));
        chk("init_ack16",   32'(h16.ack),   32'(0));
        chk("init_be_n8",   32'(m8_be_n),   32'(1));
        chk("init_ce_n8",   32'(m8_ce_n),   32'(1));
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Odd-address write on the 16-bit device.
        access(1'b0, 1'b1, 19'h7FFFF, 8'h3C, 16'h0000);
        // Read lane select.
        access(1'b0, 1'b0, 19'h00001, 8'h00, 16'h12AB);
        access(1'b0, 1'b0, 19'h00000, 8'h00, 16'h12AB);
        // 8-bit flash: read, then a write that must not strobe.
        access(1'b1, 1'b0, 19'h40000, 8'h00, 16'h005E);
        access(1'b1, 1'b1, 19'h40000, 8'h77, 16'h005E);
        // Request held high across several accesses.
        hold_req();
        // Reset during the write pulse, then prove the bridge is usable.
        reset_mid_write();
        access(1'b0, 1'b0, 19'h00005, 8'h00, 16'hC35A);

        for (int i = 0; i < 40; i++) begin
            access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 19'($urandom),
                   8'($urandom), 16'($urandom));
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
